// File: rtl/order_packet_tx.sv
// Outbound order transmitter: buffers orders in a small FIFO and serializes each
// into a 128-bit framed packet with sequence number and XOR checksum.
module order_packet_tx #(
  parameter int          DEPTH = 4,
  parameter logic [7:0]  SOF   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              order_id,
  input  logic [31:0]              order_price,
  input  logic [23:0]              order_qty,
  input  logic                     order_side,
  input  logic                     order_valid,
  output logic                     order_ready,
  input  logic                     tx_enable,
  output logic [127:0]             packet_out,
  output logic                     packet_out_valid,
  input  logic                     packet_out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              seq_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 89;
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [EW-1:0]  mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [0:0]     state;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [EW-1:0]  head;
  logic [119:0]   body;
  logic [7:0]     csum;

  // The extra pointer bit tells full (MSBs differ) from empty (pointers equal).
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign order_ready      = !full;
  assign push             = order_valid && !full;
  assign pop              = !empty && tx_enable && ((state == ST_EMPTY) || packet_out_ready);
  assign packet_out_valid = (state == ST_HOLD);
  assign fifo_level       = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {order_id, order_price, order_qty, order_side};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];
  assign body = {SOF, seq_next, head[88:57], head[56:25], head[24:1], 7'd0, head[0]};

  always_comb begin
    csum = '0;
    for (int i = 0; i < 15; i++) begin
      csum = csum ^ body[i*8 +: 8];
    end
  end

  // A pop always forms a packet, so the sequence number advances with every pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      packet_out <= '0;
      seq_next   <= '0;
    end else begin
      if (pop) begin
        state      <= ST_HOLD;
        packet_out <= {body, csum};
        seq_next   <= seq_next + 16'd1;
      end else if ((state == ST_HOLD) && packet_out_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_order_packet_tx.sv
// Self-checking bench for order_packet_tx: fixed vectors, corner sequences and a
// randomized run compared against a queue-based transaction model.
module tb_order_packet_tx;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] price;
    logic [23:0] qty;
    logic        side;
  } order_t;

  typedef struct {
    order_t       ord;
    logic [127:0] exp_pkt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   order_id = '0;
  logic [31:0]   order_price = '0;
  logic [23:0]   order_qty = '0;
  logic          order_side = 1'b0;
  logic          order_valid = 1'b0;
  logic          order_ready;
  logic          tx_enable = 1'b0;
  logic [127:0]  packet_out;
  logic          packet_out_valid;
  logic          packet_out_ready = 1'b0;
  logic [2:0]    fifo_level;
  logic [15:0]   seq_next;

  int errors = 0;
  int checks = 0;

  order_t        m_fifo [$];
  logic          m_hold = 1'b0;
  logic [127:0]  m_pkt = '0;
  logic [15:0]   m_seq = '0;
  logic          m_acc = 1'b0;

  order_t        no_order = '0;

  order_packet_tx #(.DEPTH(DEPTH), .SOF(8'hA5)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .order_id(order_id),
    .order_price(order_price),
    .order_qty(order_qty),
    .order_side(order_side),
    .order_valid(order_valid),
    .order_ready(order_ready),
    .tx_enable(tx_enable),
    .packet_out(packet_out),
    .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready),
    .fifo_level(fifo_level),
    .seq_next(seq_next)
  );

  always #5 clk = ~clk;

  // Packet built straight from the frame layout: fields then XOR of the 15 upper bytes.
  function automatic logic [127:0] make_packet(input logic [15:0] seq, input order_t o);
    logic [119:0] hdr;
    logic [7:0]   x;
    hdr = {8'hA5, seq, o.id, o.price, o.qty, 7'd0, o.side};
    x = 8'h00;
    for (int b = 0; b < 15; b++) x = x ^ hdr[b*8 +: 8];
    return {hdr, x};
  endfunction

  function automatic order_t rand_order();
    order_t o;
    o.id    = $urandom;
    o.price = $urandom;
    o.qty   = 24'($urandom);
    o.side  = 1'($urandom);
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_hold = 1'b0;
    m_pkt  = '0;
    m_seq  = '0;
  endtask

  task automatic model_step(input logic v, input order_t o, input logic te, input logic rdy);
    order_t head;
    logic   ld;
    m_acc = v && (m_fifo.size() < DEPTH);
    ld    = te && (m_fifo.size() > 0) && (!m_hold || rdy);
    if (ld) begin
      head   = m_fifo.pop_front();
      m_pkt  = make_packet(m_seq, head);
      m_seq  = m_seq + 16'd1;
      m_hold = 1'b1;
    end else if (m_hold && rdy) begin
      m_hold = 1'b0;
    end
    if (m_acc) m_fifo.push_back(o);
  endtask

  task automatic compare_model();
    checkOutput("ready", 128'(order_ready), 128'(m_fifo.size() < DEPTH));
    checkOutput("valid", 128'(packet_out_valid), 128'(m_hold));
    checkOutput("level", 128'(fifo_level), 128'(m_fifo.size()));
    checkOutput("seq_next", 128'(seq_next), 128'(m_seq));
    if (m_hold) checkOutput("packet", packet_out, m_pkt);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, check after the next fall.
  task automatic applyStimulus(input logic v, input order_t o, input logic te, input logic rdy);
    order_valid      = v;
    order_id         = o.id;
    order_price      = o.price;
    order_qty        = o.qty;
    order_side       = o.side;
    tx_enable        = te;
    packet_out_ready = rdy;
    model_step(v, o, te, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    checkOutput("rst_valid", 128'(packet_out_valid), 128'(0));
    checkOutput("rst_packet", packet_out, 128'(0));
    checkOutput("rst_level", 128'(fifo_level), 128'(0));
    checkOutput("rst_seq", 128'(seq_next), 128'(0));
    checkOutput("rst_ready", 128'(order_ready), 128'(1));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t          vecs [4];
  logic [127:0]  held;
  int            nvalid;
  int            first_v;
  int            last_v;
  int            max_level;
  logic          found;

  initial begin
    vecs[0].ord = '{id: 32'h00000011, price: 32'h00012345, qty: 24'h000064, side: 1'b1};
    vecs[0].exp_pkt = 128'hA5_0000_00000011_00012345_000064_01_B6;
    vecs[1].ord = '{id: 32'h0, price: 32'h0, qty: 24'h0, side: 1'b0};
    vecs[1].exp_pkt = 128'hA5_0001_00000000_00000000_000000_00_A4;
    vecs[2].ord = '{id: 32'hFFFFFFFF, price: 32'hFFFFFFFF, qty: 24'hFFFFFF, side: 1'b1};
    vecs[2].exp_pkt = 128'hA5_0002_FFFFFFFF_FFFFFFFF_FFFFFF_01_59;
    vecs[3].ord = '{id: 32'h12345678, price: 32'h9ABCDEF0, qty: 24'h00A0B0, side: 1'b0};
    vecs[3].exp_pkt = 128'hA5_0003_12345678_9ABCDEF0_00A0B0_00_B6;

    do_reset();

    // Fixed vectors: two-cycle latency, exact frame, valid drops the next cycle.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].ord, 1'b1, 1'b1);
      checkOutput("vec_lat_n1", 128'(packet_out_valid), 128'(0));
      applyStimulus(1'b0, no_order, 1'b1, 1'b1);
      checkOutput("vec_valid", 128'(packet_out_valid), 128'(1));
      checkOutput("vec_packet", packet_out, vecs[i].exp_pkt);
      applyStimulus(1'b0, no_order, 1'b1, 1'b1);
      checkOutput("vec_drop", 128'(packet_out_valid), 128'(0));
    end

    // Backpressure until full, then drain in order.
    do_reset();
    held = '0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, rand_order(), 1'b1, 1'b0);
      if (k == 1) held = packet_out;
      if (k >= 2) checkOutput("bp_stable", packet_out, held);
      if (k == 4) checkOutput("bp_full_ready", 128'(order_ready), 128'(0));
    end
    checkOutput("bp_level", 128'(fifo_level), 128'(DEPTH));
    for (int i = 0; i < 5; i++) begin
      checkOutput("drain_valid", 128'(packet_out_valid), 128'(1));
      checkOutput("drain_seq", 128'(packet_out[119:104]), 128'(i));
      applyStimulus(1'b0, no_order, 1'b1, 1'b1);
    end
    checkOutput("drain_done", 128'(packet_out_valid), 128'(0));

    // Streaming ten orders back to back.
    do_reset();
    nvalid = 0; first_v = -1; last_v = -1; max_level = 0;
    for (int c = 0; c < 13; c++) begin
      applyStimulus(c < 10, rand_order(), 1'b1, 1'b1);
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (packet_out_valid) begin
        checkOutput("stream_seq", 128'(packet_out[119:104]), 128'(nvalid));
        if (first_v < 0) first_v = c;
        last_v = c;
        nvalid++;
      end
    end
    checkOutput("stream_count", 128'(nvalid), 128'(10));
    checkOutput("stream_consecutive", 128'(last_v - first_v + 1), 128'(10));
    checkOutput("stream_max_level", 128'(max_level <= 1), 128'(1));

    // tx_enable low blocks packet formation.
    do_reset();
    applyStimulus(1'b1, rand_order(), 1'b0, 1'b1);
    applyStimulus(1'b1, rand_order(), 1'b0, 1'b1);
    applyStimulus(1'b0, no_order, 1'b0, 1'b1);
    applyStimulus(1'b0, no_order, 1'b0, 1'b1);
    checkOutput("gate_valid", 128'(packet_out_valid), 128'(0));
    checkOutput("gate_seq", 128'(seq_next), 128'(0));
    checkOutput("gate_level", 128'(fifo_level), 128'(2));
    applyStimulus(1'b0, no_order, 1'b1, 1'b1);
    checkOutput("gate_pkt0", 128'(packet_out[119:104]), 128'(0));
    applyStimulus(1'b0, no_order, 1'b1, 1'b1);
    checkOutput("gate_pkt1_valid", 128'(packet_out_valid), 128'(1));
    checkOutput("gate_pkt1", 128'(packet_out[119:104]), 128'(1));

    // Reset while holding a packet with three more buffered.
    do_reset();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, rand_order(), 1'b1, 1'b0);
    checkOutput("mid_hold", 128'(packet_out_valid), 128'(1));
    checkOutput("mid_level", 128'(fifo_level), 128'(3));
    do_reset();
    applyStimulus(1'b1, vecs[0].ord, 1'b1, 1'b1);
    applyStimulus(1'b0, no_order, 1'b1, 1'b1);
    checkOutput("mid_after_pkt", packet_out, vecs[0].exp_pkt);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, rand_order(), $urandom_range(0, 7) != 0,
                    $urandom_range(0, 2) != 0);
    end

    // Sequence wrap through a long streaming run.
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 66000 && !found; c++) begin
      applyStimulus(1'b1, rand_order(), 1'b1, 1'b1);
      if (packet_out_valid && packet_out[119:104] == 16'hFFFF) found = 1'b1;
    end
    checkOutput("wrap_found", 128'(found), 128'(1));
    applyStimulus(1'b1, rand_order(), 1'b1, 1'b1);
    checkOutput("wrap_seq0", 128'(packet_out[119:104]), 128'(0));
    checkOutput("wrap_seq_next", 128'(seq_next), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
